// File: rtl/uart_frame_parser.sv
// Framed-packet parser behind a UART byte receiver: HDR, LEN, PAYLOAD[LEN], CSUM.
// Payload is buffered and released on a valid/ready stream only after the checksum matches.
module uart_frame_parser #(
    parameter int         MAX_LEN      = 16,
    parameter logic [7:0] HDR          = 8'hA5,
    parameter int         TIMEOUT_CLKS = 156240
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [1:0] err_code,
    output logic       overrun,
    output logic       busy
);

    localparam int IDX_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
    localparam int GAP_W = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [GAP_W-1:0] GAP_TC    = GAP_W'(TIMEOUT_CLKS - 1);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CSUM,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       len_q, len_d;
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       wr_idx_q, wr_idx_d;
    logic [7:0]       rd_idx_q, rd_idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             out_last_q, out_last_d;
    logic             frame_ok_q, frame_ok_d;
    logic             frame_err_q, frame_err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             overrun_q, overrun_d;
    logic             mem_we;

    logic [7:0] pay_mem [MAX_LEN];

    always_ff @(posedge sys_clk) begin
        if (mem_we) begin
            pay_mem[wr_idx_q[IDX_W-1:0]] <= rx_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        sum_d       = sum_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        gap_d       = '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        overrun_d   = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid && rx_data == HDR) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > MAX_LEN_B) begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd1;
                        state_d     = S_IDLE;
                    end else begin
                        len_d    = rx_data;
                        sum_d    = rx_data;
                        wr_idx_d = 8'd0;
                        state_d  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (rx_valid) begin
                    mem_we   = 1'b1;
                    sum_d    = sum_q + rx_data;
                    wr_idx_d = wr_idx_q + 8'd1;
                    if (wr_idx_q + 8'd1 == len_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (rx_valid) begin
                    if (rx_data == sum_q) begin
                        frame_ok_d = 1'b1;
                        rd_idx_d   = 8'd0;
                        state_d    = S_DRAIN;
                    end else begin
                        frame_err_d = 1'b1;
                        err_code_d  = 2'd2;
                        state_d     = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                overrun_d = rx_valid;
                // rd_idx is the fetch pointer: it runs one ahead of the byte on out_data.
                if (!out_valid_q || (out_ready && !out_last_q)) begin
                    out_data_d  = pay_mem[rd_idx_q[IDX_W-1:0]];
                    out_valid_d = 1'b1;
                    out_last_d  = (rd_idx_q == len_q - 8'd1);
                    rd_idx_d    = rd_idx_q + 8'd1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Inter-byte gap watchdog; a byte arriving on the terminal count wins.
        if ((state_q == S_LEN || state_q == S_PAYLOAD || state_q == S_CSUM) && !rx_valid) begin
            if (gap_q == GAP_TC) begin
                frame_err_d = 1'b1;
                err_code_d  = 2'd3;
                state_d     = S_IDLE;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            sum_q       <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            gap_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            sum_q       <= sum_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            gap_q       <= gap_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign frame_ok  = frame_ok_q;
    assign frame_err = frame_err_q;
    assign err_code  = err_code_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/uart_frame_parser.md
Name: uart_frame_parser

Overview:
- Sits directly downstream of the UART byte receiver (50 MHz sys_clk, 9600 baud, 5208 clocks/bit).
- Consumes received bytes and assembles framed packets of the form HDR, LEN, PAYLOAD[LEN], CSUM.
- Buffers the payload internally and releases it on a valid/ready stream only after the checksum is verified.
- Reports good and bad frames with single-cycle pulses.

Parameters:
- MAX_LEN, 16, maximum payload bytes; also the depth of the buffer (2..255).
- HDR, 8'hA5, start-of-frame byte.
- TIMEOUT_CLKS, 156240, maximum clocks between consecutive bytes inside a frame (3 byte times at 9600 baud).

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  received byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in this cycle.
- out_data  out  8  payload byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts the byte when out_valid && out_ready.
- out_last  out  1  marks the final payload byte; qualified by out_valid.
- frame_ok  out  1  one-cycle pulse when a frame passes the checksum.
- frame_err  out  1  one-cycle pulse on a frame error.
- err_code  out  2  cause of the last error: 1 = bad LEN, 2 = checksum mismatch, 3 = timeout. Holds until the next error.
- overrun  out  1  one-cycle pulse when a byte is dropped during DRAIN.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state IDLE. out_valid, out_last, frame_ok, frame_err, overrun = 0. out_data = 0, err_code = 0. All counters and the running sum = 0.
- FSM states: IDLE, LEN, PAYLOAD, CSUM, DRAIN. All registered; each transition happens on the clock edge where rx_valid is sampled.
- IDLE:
  - rx_valid with rx_data == HDR -> LEN.
  - Any other byte is ignored silently (no error).
- LEN (on rx_valid):
  - rx_data == 0 or > MAX_LEN -> frame_err pulse, err_code = 1, -> IDLE.
  - Otherwise latch len = rx_data, sum = rx_data, wr_idx = 0, -> PAYLOAD.
- PAYLOAD (on rx_valid):
  - buf[wr_idx] = rx_data, sum = sum + rx_data (8-bit, modulo 256), wr_idx++.
  - When wr_idx reaches len, -> CSUM.
  - A byte equal to HDR is treated as payload data, not as a resync.
- CSUM (on rx_valid):
  - rx_data == sum -> frame_ok pulse, rd_idx = 0, -> DRAIN.
  - Otherwise frame_err pulse, err_code = 2, -> IDLE; the buffer contents are discarded.
- Timeout:
  - In LEN, PAYLOAD and CSUM, a gap counter clears on each rx_valid and increments every other clock.
  - When the counter reaches TIMEOUT_CLKS-1 -> frame_err pulse, err_code = 3, -> IDLE.
  - The counter is held at 0 in IDLE and DRAIN.
- DRAIN:
  - out_valid = 1 and out_data = buf[rd_idx], registered.
  - out_valid rises on the first cycle after the frame_ok cycle.
  - out_last = (rd_idx == len-1).
  - On out_valid && out_ready: rd_idx++. On the last byte, out_valid drops the next cycle and the FSM goes to IDLE.
  - out_data and out_valid must remain stable while out_ready = 0.
  - Throughput: one byte per clock with out_ready held high; len bytes drain in len cycles.
- rx_valid during DRAIN: the byte is dropped and overrun pulses, including when the byte equals HDR.
- Simultaneous events:
  - rx_valid in the same cycle as the timeout terminal count: the byte wins, the counter clears and no error is raised.
  - The last-byte handshake in DRAIN together with rx_valid: the FSM goes to IDLE, the byte is dropped and overrun pulses.
- Reset mid-frame or mid-drain: immediate return to the reset state; no pulses are emitted.
- frame_ok and frame_err are never high in the same cycle.
- busy = (state != IDLE).

Test Plan:
- Good frame: A5 03 11 22 33 69 sent at 9600 baud, out_ready = 1.
  - Required: frame_ok pulses once.
  - out_data sequence 11, 22, 33 on 3 consecutive cycles; out_last is high only with 33.
  - busy returns to 0; frame_err never pulses.
- Bad checksum: A5 02 10 20 00.
  - Required: frame_err pulses with err_code = 2.
  - out_valid never rises; the FSM is back in IDLE.
  - A following good frame A5 01 7F 80 is delivered (out_data 7F, out_last high).
- Bad length: A5 00, then separately A5 11 with MAX_LEN = 16.
  - Required: each gives frame_err with err_code = 1 and a return to IDLE.
- Timeout: A5 02 44, then an idle line for more than 156240 clocks.
  - Required: frame_err with err_code = 3 exactly TIMEOUT_CLKS clocks after the 44 strobe.
  - A next frame A5 01 00 01 succeeds.
- Backpressure: good frame A5 04 01 02 03 04 0E with out_ready toggling 1, 0, 0, 1, ...
  - Required: each byte is held stable while out_ready = 0.
  - All 4 bytes are delivered in order; out_last is high with 04.
- Overrun and reset: rx_valid with A5 is injected while DRAIN is stalled (out_ready = 0).
  - Required: overrun pulses and the drain continues unaffected.
  - Then assert rst_n = 0 mid-PAYLOAD: all outputs go to their reset values asynchronously and no frame_ok or frame_err pulse is emitted.
